// File: rtl/magnitude_sched_pkg.sv
// magnitude_sched_pkg: shared FSM state type and counter widths for magnitude_sched
package magnitude_sched_pkg;
  typedef enum logic [1:0] {IDLE, SETTLE, RESP} state_t;
  localparam int CNT_W  = 4;
  localparam int DONE_W = 16;
endpackage

// File: rtl/magnitude_sched_magnitude.sv
// magnitude: combinational vectoring CORDIC returning |(x,y)| in the operand Q format
module magnitude #(
  parameter int WIDTH           = 17,
  parameter int FRACTIONAL_BITS = 12,
  parameter int ITERATIONS      = 16
) (
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  output logic        [WIDTH-1:0] mag
);
  // Guard bits absorb the per-stage truncation of the arithmetic shifts.
  localparam int G   = $clog2(ITERATIONS) + 1;
  // Two headroom bits cover the sqrt(2) vector growth times the CORDIC gain.
  localparam int XW  = WIDTH + 2 + G;
  // The inverse gain is held four bits finer than the data format.
  localparam int KSH = FRACTIONAL_BITS + 4;
  localparam int PW  = XW + KSH + 1;
  localparam real K_INV_R = 0.6072529350088813;
  localparam logic [KSH:0] K_INV = (KSH+1)'($rtoi(K_INV_R * (2.0 ** KSH) + 0.5));
  localparam logic [PW-1:0] MAX_P = PW'({1'b0, {(WIDTH-1){1'b1}}});
  logic signed [XW-1:0] xs [ITERATIONS+1];
  logic signed [XW-1:0] ys [ITERATIONS+1];
  logic signed [XW-1:0] xe, ye;
  logic [PW-1:0] prod, full;
  // Fold the left half-plane onto the right, rotate y to zero, then remove the CORDIC gain with rounding.
  always_comb begin
    xe = XW'(x) <<< G;
    ye = XW'(y) <<< G;
    xs[0] = x[WIDTH-1] ? -xe : xe;
    ys[0] = x[WIDTH-1] ? -ye : ye;
    for (int i = 0; i < ITERATIONS; i++) begin
      xs[i+1] = !ys[i][XW-1] ? xs[i] + (ys[i] >>> i) : xs[i] - (ys[i] >>> i);
      ys[i+1] = !ys[i][XW-1] ? ys[i] - (xs[i] >>> i) : ys[i] + (xs[i] >>> i);
    end
    prod = PW'($unsigned(xs[ITERATIONS])) * PW'(K_INV) + (PW'(1) << (KSH + G - 1));
    full = prod >> (KSH + G);
    mag  = (full > MAX_P) ? MAX_P[WIDTH-1:0] : full[WIDTH-1:0];
  end
endmodule

// File: rtl/magnitude_sched.sv
// magnitude_sched: round-robin scheduler sharing one CORDIC magnitude core; MAGNITUDE_SCHED_PERF_EN adds done_count
module magnitude_sched
  import magnitude_sched_pkg::*;
#(
  parameter int WIDTH           = 17,
  parameter int FRACTIONAL_BITS = 12,
  parameter int ITERATIONS      = 16,
  parameter int NUM_REQ         = 3,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_x,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_y,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id,
  output logic [WIDTH-1:0]                rsp_mag,
  output logic                            busy
`ifdef MAGNITUDE_SCHED_PERF_EN
  ,
  output logic [DONE_W-1:0]               done_count
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0] last_q, last_d, id_q, id_d, sel, cand;
  logic signed [WIDTH-1:0] op_x_q, op_x_d, op_y_q, op_y_d;
  logic [WIDTH-1:0] mag_q, mag_d, core_mag;
  logic rsp_valid_q, rsp_valid_d, found, accept;
  int idx;
  magnitude #(
    .WIDTH          (WIDTH),
    .FRACTIONAL_BITS(FRACTIONAL_BITS),
    .ITERATIONS     (ITERATIONS)
  ) u_mag (
    .x  (op_x_q),
    .y  (op_y_q),
    .mag(core_mag)
  );
  // Round-robin pick: first valid requester after the last grant.
  always_comb begin
    sel   = '0;
    cand  = '0;
    idx   = 0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(last_q) + k) % NUM_REQ;
      cand = IW'(idx);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end
  assign accept    = (state_q == IDLE) && found && !rst;
  assign req_ready = accept ? (NUM_REQ'(1) << sel) : '0;
  assign busy      = (state_q != IDLE) && !rst;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_mag   = mag_q;
  // Next-state: capture on accept, count down the settle window, hold the result until handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    id_d        = id_q;
    op_x_d      = op_x_q;
    op_y_d      = op_y_q;
    mag_d       = mag_q;
    rsp_valid_d = rsp_valid_q;
    if (state_q == IDLE) begin
      if (accept) begin
        op_x_d  = req_x[sel];
        op_y_d  = req_y[sel];
        id_d    = sel;
        last_d  = sel;
        cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
    end else if (state_q == SETTLE) begin
      if (cnt_q == '0) begin
        mag_d       = core_mag;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (state_q == RESP) begin
      if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  // State and datapath registers; reset gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IW'(NUM_REQ - 1);
      id_q        <= '0;
      op_x_q      <= '0;
      op_y_q      <= '0;
      mag_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      id_q        <= id_d;
      op_x_q      <= op_x_d;
      op_y_q      <= op_y_d;
      mag_q       <= mag_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end
`ifdef MAGNITUDE_SCHED_PERF_EN
  logic [DONE_W-1:0] done_count_q, done_count_d;
  assign done_count = done_count_q;
  // Saturating count of completed response handshakes.
  always_comb begin
    done_count_d = (rsp_valid_q && rsp_ready && done_count_q != '1) ? done_count_q + 1'b1 : done_count_q;
  end
  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) done_count_q <= '0;
    else     done_count_q <= done_count_d;
  end
`endif
endmodule
